// File: rtl/rf_dump_streamer_if.sv
// Register-file read port and byte-stream handshake shared by the dump
// streamer (master) and its register file / transmitter (slave).
interface rf_dump_streamer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output rf_addr,
    input  rf_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/rf_dump_streamer.sv
// Debug readback engine: walks an inclusive (wrapping) register range on a
// dedicated asynchronous read port and streams each word out as bytes,
// optionally preceded by a header byte holding the register address.
module rf_dump_streamer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int SEND_HEADER = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] first_addr_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  rf_dump_streamer_if.master    bus
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_HDR  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer_s;

  // Little-endian byte select: byte 0 is bits 7:0.
  function automatic logic [7:0] word_byte(input logic [DATA_WIDTH-1:0] w,
                                           input logic [IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] shifted;
    shifted = w >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

  assign xfer_s = tx_valid_q && bus.tx_ready;

  // State register plus datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update; a stalled transfer leaves everything held.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = first_addr_i;
          last_d  = last_addr_i;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        word_d  = bus.rf_data;
        idx_d   = '0;
        state_d = (SEND_HEADER != 0) ? S_HDR : S_SEND;
      end
      S_HDR: begin
        if (xfer_s) begin
          state_d = S_SEND;
        end else begin
          state_d = S_HDR;
        end
      end
      S_SEND: begin
        if (xfer_s) begin
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (addr_q == last_q) begin
            state_d = S_DONE;
          end else begin
            // Natural wrap of the address width gives the modulo increment.
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_READ;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs leave a flop.
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    case (state_d)
      S_HDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'(addr_d);
      end
      S_SEND: begin
        tx_valid_d = 1'b1;
        tx_data_d  = word_byte(word_d, idx_d);
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  assign bus.rf_addr  = addr_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Scoreboard bench for rf_dump_streamer: expected bytes are derived from the
// requested range and a register-file array; a negedge monitor compares them.
module tb_rf_dump_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        busy;
  logic        done;

  logic [31:0] rf_mem [32];
  logic [7:0]  exp_q [$];

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;     // 0: always ready, 1: random
  bit addr_check_en = 1'b0;
  int cur_first = 0;
  int cur_last  = 0;
  int xfer_cnt  = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit prev_done = 1'b0;

  rf_dump_streamer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rf_dump_streamer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SEND_HEADER(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .busy_o       (busy),
    .done_o       (done),
    .bus          (bus.master)
  );

  assign bus.rf_data = rf_mem[bus.rf_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sink readiness, changed just after each rising edge.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) bus.tx_ready = 1'($urandom_range(0, 1));
      else bus.tx_ready = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input int a);
    return ((a - cur_first + 32) % 32) <= ((cur_last - cur_first + 32) % 32);
  endfunction

  // Monitor: transfers, stall stability, done pulse and address range.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(bus.tx_valid), 32'd1);
        check("stall_data_held", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", 32'(bus.tx_data), 32'hffff_ffff);
        else check("stream_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        check("done_after_last_byte", 32'(exp_q.size()), 32'd0);
        check("done_single_pulse", 32'(prev_done), 32'd0);
      end
      if (addr_check_en && busy) check("rf_addr_in_range", 32'(in_range(int'(bus.rf_addr))), 32'd1);
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_done  = done;
    end
  end

  // Expected byte stream for an inclusive, wrapping range.
  task automatic push_expected(input int f, input int l);
    int n;
    int a;
    logic [31:0] w;
    n = ((l - f + 32) % 32) + 1;
    for (int i = 0; i < n; i++) begin
      a = (f + i) % 32;
      w = rf_mem[a];
      exp_q.push_back(8'(a));
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // Drive start for one cycle; returns just after the edge that samples it.
  task automatic start_dump(input int f, input int l);
    @(posedge clk);
    #1;
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start      = 1'b1;
    cur_first  = f;
    cur_last   = l;
    push_expected(f, l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded by budget.
  task automatic wait_done(input int budget, output int cnt);
    bit got;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < budget) begin
      @(negedge clk);
      cnt++;
      got = done;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int c;
    int base;
    int f;
    int l;
    rst_n = 1'b0;
    start = 1'b0;
    first_addr = 5'd0;
    last_addr  = 5'd0;
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;

    // Reset state
    @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;

    // Single register with latency checks
    rf_mem[2] = 32'h7fffefe4;
    start_dump(2, 2);
    @(negedge clk);
    check("lat_read_bubble", 32'(bus.tx_valid), 32'd0);
    check("busy_in_read", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_first_valid", 32'(bus.tx_valid), 32'd1);
    check("first_is_header", 32'(bus.tx_data), 32'h02);
    wait_done(50, c);
    check("single_word_cycles", 32'(c + 3), 32'd8);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_cleared", 32'(done), 32'd0);

    // Full range, 32 words
    base = xfer_cnt;
    start_dump(0, 31);
    wait_done(400, c);
    check("full_range_cycles", 32'(c + 1), 32'(1 + 32 * 6 + 1));
    check("full_range_bytes", 32'(xfer_cnt - base), 32'd160);

    // Wrap through the top of the address space
    addr_check_en = 1'b1;
    start_dump(30, 1);
    wait_done(100, c);
    check("wrap_cycles", 32'(c + 1), 32'(1 + 4 * 6 + 1));
    addr_check_en = 1'b0;

    // Backpressure on a single word
    rf_mem[9] = 32'ha5b6c7d8;
    ready_mode = 1;
    base = xfer_cnt;
    start_dump(9, 9);
    wait_done(300, c);
    check("backpressure_bytes", 32'(xfer_cnt - base), 32'd5);
    ready_mode = 0;

    // Start and range changes while busy are ignored
    addr_check_en = 1'b1;
    start_dump(4, 10);
    repeat (5) @(posedge clk);
    #1;
    first_addr = 5'd20;
    last_addr  = 5'd25;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_addr = 5'd7;
    last_addr  = 5'd3;
    wait_done(200, c);
    check("ignored_start_cycles", 32'(c + 7), 32'(1 + 7 * 6 + 1));
    addr_check_en = 1'b0;
    @(negedge clk);
    check("idle_after_ignored", 32'(busy), 32'd0);

    // Randomized ranges, data and backpressure
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      addr_check_en = 1'b1;
      start_dump(f, l);
      wait_done(3000, c);
      addr_check_en = 1'b0;
      check("random_queue_drained", 32'(exp_q.size()), 32'd0);
    end
    ready_mode = 0;

    // Asynchronous reset while byte 2 is on the bus
    rf_mem[5] = 32'h11223344;
    start_dump(5, 5);
    c = 0;
    while (!(bus.tx_valid && bus.tx_data == 8'h22) && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("reached_byte2", 32'(bus.tx_data), 32'h22);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("async_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("async_rst_rf_addr", 32'(bus.rf_addr), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    start_dump(12, 13);
    wait_done(100, c);
    check("post_reset_cycles", 32'(c + 1), 32'(1 + 2 * 6 + 1));
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
